// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NREQ byte-stream requesters. Arbitration
// is packet-granular round-robin: once a requester is granted, it keeps the
// grant until the byte flagged req_last has been handed to the UART and the
// UART reports idle again.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable a mid-packet idle
// timeout. While the owner leaves req_valid low in ACCEPT for TIMEOUT cycles,
// the grant is revoked and a one-cycle timeout pulse is produced. Without the
// macro the counter does not exist and timeout is tied low.
//
// Parameters
//   NREQ     number of requesters (2..4)
//   TIMEOUT  mid-packet idle limit in clk cycles (1..255)
//
// Ports
//   clk        in   master clock
//   rst        in   synchronous active-high reset
//   req_valid  in   [NREQ]    per-requester byte available
//   req_byte   in   [8*NREQ]  requester i drives bits [8i+7:8i]
//   req_last   in   [NREQ]    byte closes its packet
//   req_ready  out  [NREQ]    one-hot single-cycle accept pulse
//   grant      out  [NREQ]    one-hot current owner, zero when none
//   transmit   out            start strobe to the UART
//   tx_byte    out  [8]       byte handed to the UART
//   tx_free    in             UART idle
//   busy       out            arbiter not in IDLE
//   timeout    out            grant revoked by the idle timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_byte,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    input  logic              tx_free,
    output logic              busy,
    output logic              timeout
);

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;

    // Reject out-of-range configurations at elaboration.
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("uart_tx_arbiter: NREQ must be 2..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ACCEPT    = 2'd1,
        S_ISSUE     = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_last_owner;
    logic              r_last;
    logic              r_transmit;
    logic [7:0]        r_tx_byte;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic              r_timeout;
    logic [7:0]        r_idle_cnt;
`endif

    logic [IDX_W-1:0]  w_next_idx;
    logic              w_any_valid;
    logic              w_own_valid;
    logic              w_own_last;
    logic [7:0]        w_own_byte;
    logic              w_accept;

    // Round-robin pick starting at last+1. Candidates are visited from the
    // lowest priority (last itself) to the highest (last+1), so the final
    // overwrite is the nearest valid requester after last.
    function automatic logic [IDX_W-1:0] f_rr_pick(
        input logic [NREQ-1:0]  valid,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] pick;
        int               j;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= NREQ) j = j - NREQ;
            if (valid[IDX_W'(j)]) pick = IDX_W'(j);
        end
        return pick;
    endfunction

    assign w_next_idx  = f_rr_pick(req_valid, r_last_owner);
    assign w_any_valid = |req_valid;

    // Owner signals are selected through the one-hot grant, so non-owner
    // inputs can never leak into the datapath.
    assign w_own_valid = |(req_valid & r_grant);
    assign w_own_last  = |(req_last & r_grant);

    always_comb begin
        w_own_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) w_own_byte = req_byte[8*i +: 8];
        end
    end

    // The handshake is a same-cycle acknowledge of the presented byte; it is
    // decoded from registered state and only ever lasts one cycle because
    // the FSM leaves ACCEPT on the following edge.
    assign w_accept  = (r_state == S_ACCEPT) && w_own_valid && tx_free;
    assign req_ready = w_accept ? r_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(NREQ - 1);
            r_last       <= 1'b0;
            r_transmit   <= 1'b0;
            r_tx_byte    <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_timeout    <= 1'b0;
            r_idle_cnt   <= 8'h00;
`endif
        end else begin
            r_transmit <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_timeout  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_grant <= NREQ'(1) << w_next_idx;
                        r_owner <= w_next_idx;
                        r_state <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (w_accept) begin
                        r_tx_byte  <= w_own_byte;
                        r_last     <= w_own_last;
                        r_transmit <= 1'b1;
                        r_state    <= S_ISSUE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        r_idle_cnt <= 8'h00;
`endif
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    // Only owner starvation counts; waiting on the UART does not.
                    else if (!w_own_valid) begin
                        if (r_idle_cnt == 8'(TIMEOUT - 1)) begin
                            r_timeout    <= 1'b1;
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_idle_cnt   <= 8'h00;
                            r_state      <= S_IDLE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 8'd1;
                        end
                    end
`endif
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tx_free) begin
                        if (r_last) begin
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_ACCEPT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign transmit = r_transmit;
    assign tx_byte  = r_tx_byte;
    assign busy     = (r_state != S_IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign timeout  = r_timeout;
`else
    assign timeout  = 1'b0;
`endif

endmodule
